mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port (data cache / instruction cache) arbiter onto a
// single external memory bus. One transaction at a time, IDLE -> BUSY -> DONE,
// round-robin on simultaneous requests.
// Optional feature: define ARB_TIMEOUT_EN to enable the BUSY-state watchdog
// (TIMEOUT_CYCLES); without it err is tied low and BUSY waits for mem_ack.
module mem_bus_arbiter #(
   parameter int ADDR_W         = 9,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              rw0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   input  logic              req1,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic              owner;        // 0 = port 0, 1 = port 1
   logic              last_served;  // port granted most recently
   logic              pick;         // owner chosen from the current requests
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              tmo_hit;      // watchdog expiry in this BUSY cycle

   // On a tie the port not served last wins; otherwise whoever is asking.
   assign pick = (req0 && req1) ? ~last_served : req1;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [CNT_W-1:0] tcnt;
   logic             err_q;

   assign tmo_hit = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ack;

   // Watchdog: counts BUSY cycles, remembers an expiry until DONE is left.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == BUSY) tcnt <= tcnt + 1'b1;
         else               tcnt <= '0;
         if (state == BUSY && tmo_hit) err_q <= 1'b1;
         else if (state == IDLE)       err_q <= 1'b0;
      end
   end

   assign err = err_q && (state == DONE);
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   // State register; reset returns to IDLE and abandons any open transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and bus/grant outputs, all decoded from the current state.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      case (state)
         IDLE: if (req0 || req1) state_nxt = BUSY;
         BUSY: begin
            mem_req = 1'b1;
            if (mem_ack || tmo_hit) state_nxt = DONE;
         end
         DONE: begin
            gnt0      = ~owner;
            gnt1      = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction registers: capture the owner's request, return read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner       <= 1'b0;
         last_served <= 1'b1;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
      end else begin
         case (state)
            IDLE: if (req0 || req1) begin
               owner   <= pick;
               rw_q    <= pick ? rw1    : rw0;
               addr_q  <= pick ? addr1  : addr0;
               wdata_q <= pick ? wdata1 : wdata0;
            end
            BUSY: begin
               if (mem_ack) begin
                  if (!rw_q) rdata_q <= mem_rdata;
               end else if (tmo_hit) begin
                  rdata_q <= '0;
               end
            end
            DONE: last_served <= owner;
            default: ;
         endcase
      end
   end

   assign mem_rw    = rw_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: reset state, single read, single
// write, stray mem_ack, reset mid-transaction, round-robin under contention,
// abandoned request during BUSY and the ARB_TIMEOUT_EN-dependent stall case.
module tb_mem_bus_arbiter;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0, rw0, req1, rw1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic [DATA_W-1:0] rdata;
   logic              mem_req, mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;

   mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
      .rdata(rdata),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (mem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(mem_req), 32'd1);
   endtask

   task automatic serve(input int port, input logic [7:0] rd, input string tag);
      wait_req({tag, "_mem_req"});
      chk({tag, "_addr"}, 32'(mem_addr), (port == 0) ? 32'h1A5 : 32'h0F0);
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0;
      chk({tag, "_gnt0"}, 32'(gnt0), (port == 0) ? 32'd1 : 32'd0);
      chk({tag, "_gnt1"}, 32'(gnt1), (port == 1) ? 32'd1 : 32'd0);
      chk({tag, "_rdata"}, 32'(rdata), 32'(rd));
      @(negedge clk);
   endtask

   initial begin
      logic any_bad;
      int   cnt;

      reset = 1'b0;
      req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
      mem_rdata = '0; mem_ack = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_mem_req",   32'(mem_req),   32'd0);
      chk("rst_gnt0",      32'(gnt0),      32'd0);
      chk("rst_gnt1",      32'(gnt1),      32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_mem_rw",    32'(mem_rw),    32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_rdata",     32'(rdata),     32'd0);

      // port 0 read of 0x1A5, ack one cycle after mem_req
      reset = 1'b1;
      req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h1A5;
      @(negedge clk);
      chk("rd_mem_req",  32'(mem_req),  32'd1);
      chk("rd_mem_addr", 32'(mem_addr), 32'h1A5);
      chk("rd_mem_rw",   32'(mem_rw),   32'd0);
      chk("rd_no_early_gnt", 32'(gnt0), 32'd0);
      @(negedge clk);
      chk("rd_mem_req_hold", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 8'h3C;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 8'h00;
      chk("rd_gnt0",    32'(gnt0),    32'd1);
      chk("rd_gnt1",    32'(gnt1),    32'd0);
      chk("rd_rdata",   32'(rdata),   32'h3C);
      chk("rd_mem_req_drop", 32'(mem_req), 32'd0);
      chk("rd_err",     32'(err),     32'd0);
      req0 = 1'b0;
      @(negedge clk);
      chk("rd_gnt0_one_cycle", 32'(gnt0), 32'd0);

      // port 1 write of 0xF0 to 0x007; inputs change during BUSY
      req1 = 1'b1; rw1 = 1'b1; addr1 = 9'h007; wdata1 = 8'hF0;
      @(negedge clk);
      chk("wr_mem_req",   32'(mem_req),   32'd1);
      chk("wr_mem_rw",    32'(mem_rw),    32'd1);
      chk("wr_mem_addr",  32'(mem_addr),  32'h007);
      chk("wr_mem_wdata", 32'(mem_wdata), 32'hF0);
      wdata1 = 8'h11; addr1 = 9'h1FF;
      @(negedge clk);
      chk("wr_wdata_stable", 32'(mem_wdata), 32'hF0);
      chk("wr_addr_stable",  32'(mem_addr),  32'h007);
      mem_ack = 1'b1; mem_rdata = 8'h55;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("wr_gnt1", 32'(gnt1), 32'd1);
      chk("wr_gnt0", 32'(gnt0), 32'd0);
      chk("wr_rdata_kept", 32'(rdata), 32'h3C);
      req1 = 1'b0; rw1 = 1'b0;
      @(negedge clk);
      chk("wr_gnt1_one_cycle", 32'(gnt1), 32'd0);

      // mem_ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 8'h99;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
      chk("stray_ack_rdata",   32'(rdata),   32'h3C);
      @(negedge clk);
      chk("stray_ack_no_gnt", 32'(gnt0 | gnt1), 32'd0);

      // reset during BUSY drops mem_req at once, no grant afterwards
      req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h0AA;
      wait_req("rstmid_mem_req");
      #2 reset = 1'b0;
      #1 chk("rstmid_async_drop", 32'(mem_req), 32'd0);
      chk("rstmid_no_gnt", 32'(gnt0 | gnt1), 32'd0);
      req0 = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      any_bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         any_bad = any_bad | gnt0 | gnt1 | mem_req;
      end
      chk("rstmid_quiet_after", 32'(any_bad), 32'd0);
      chk("rstmid_rdata_clr",   32'(rdata),   32'd0);

      // both ports held: port0, port1, port0, port1
      addr0 = 9'h1A5; rw0 = 1'b0; addr1 = 9'h0F0; rw1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      serve(0, 8'h01, "rr1");
      serve(1, 8'h02, "rr2");
      serve(0, 8'h03, "rr3");
      serve(1, 8'h04, "rr4");
      req0 = 1'b0; req1 = 1'b0;

      // request withdrawn during BUSY; memory stalls
      req0 = 1'b1; rw0 = 1'b0; addr0 = 9'h123;
      wait_req("stall_mem_req");
      req0 = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt = 0;
      while (mem_req === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      chk("tmo_busy_cycles", 32'(cnt),   32'd15);
      chk("tmo_gnt0",        32'(gnt0),  32'd1);
      chk("tmo_err",         32'(err),   32'd1);
      chk("tmo_rdata",       32'(rdata), 32'd0);
      @(negedge clk);
      chk("tmo_err_clear",   32'(err),   32'd0);
`else
      cnt = 0;
      any_bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         cnt++;
         if (mem_req !== 1'b1 || err !== 1'b0 || gnt0 !== 1'b0) any_bad = 1'b1;
      end
      chk("stall_hold", 32'(any_bad), 32'd0);
      mem_ack = 1'b1; mem_rdata = 8'h77;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stall_gnt0",  32'(gnt0),  32'd1);
      chk("stall_rdata", 32'(rdata), 32'h77);
      chk("stall_err",   32'(err),   32'd0);
      @(negedge clk);
      chk("stall_gnt0_one_cycle", 32'(gnt0), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
